field_write_sched: RTL and testbench

Write scheduler for a small packed register array `data[WORDS][WIDTH]` that is updated through dynamically indexed `[off +: FIELD]` part-selects.
- Two requesters share the single write port, with round-robin arbitration.
- A clear engine zeroes a whole word by sweeping field-aligned slices, one per cycle.
- Offsets that fall partly or fully outside the word are clipped bit by bit rather than rejected.

It sits between firmware-style field writers and the storage, and serves as the reference sequencer for dynamic part-select writes.

---
 rtl/field_write_sched.sv | 162 ++++++++++++++++
 tb/tb_field_write_sched.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/field_write_sched.sv
`default_nettype none
// ============================================================================
// Module  : field_write_sched
// Purpose : Round-robin scheduler of clipped [off +: FIELD] writes into a
//           small register array, with a slice-by-slice word-clear engine.
// Revision: 1.0 - initial release
// ============================================================================
module field_write_sched #(
  parameter int WORDS = 2,
  parameter int WIDTH = 32,
  parameter int FIELD = 8,
  parameter int OFFW  = 8,
  parameter int IDXW  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IDXW-1:0]  req0_word,
  input  logic [OFFW-1:0]  req0_off,
  input  logic [FIELD-1:0] req0_data,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IDXW-1:0]  req1_word,
  input  logic [OFFW-1:0]  req1_off,
  input  logic [FIELD-1:0] req1_data,
  input  logic             clr_valid,
  output logic             clr_ready,
  input  logic [IDXW-1:0]  clr_word,
  input  logic [IDXW-1:0]  rd_word,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             err
);

  localparam int C_SLICES = WIDTH / FIELD;
  localparam int C_KW     = (C_SLICES > 1) ? $clog2(C_SLICES) : 1;
  localparam int C_FW     = (FIELD > 1) ? $clog2(FIELD) : 1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [C_KW-1:0]    r_k;
  logic               r_last_grant;
  logic [IDXW-1:0]    r_clr_word;
  logic               r_err;
  logic [WIDTH-1:0]   r_data [WORDS];
  logic [WIDTH-1:0]   r_rd_data;

  logic                   w_wr;
  logic [IDXW-1:0]        w_word;
  logic signed [OFFW-1:0] w_off;
  logic [FIELD-1:0]       w_data;
  logic [WIDTH-1:0]       w_mask;
  logic [WIDTH-1:0]       w_val;
  logic [WIDTH-1:0]       w_clr_mask;
  logic [WIDTH-1:0]       w_rd;
  logic [WORDS-1:0]       w_wsel;
  logic [WORDS-1:0]       w_csel;
  logic [WORDS-1:0]       w_cin;

  // Arbitration: clear beats writes; on a tie the requester not granted last wins.
  always_comb begin
    w_next     = r_state;
    clr_ready  = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (clr_valid) begin
          clr_ready = 1'b1;
          w_next    = S_CLEAR;
        end else if (req0_valid && (!req1_valid || r_last_grant)) begin
          req0_ready = 1'b1;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
        end
      end
      S_CLEAR: begin
        if (r_k == C_KW'(C_SLICES - 1)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  assign w_wr   = req0_ready | req1_ready;
  assign w_word = req1_ready ? req1_word : req0_word;
  assign w_off  = req1_ready ? $signed(req1_off) : $signed(req0_off);
  assign w_data = req1_ready ? req1_data : req0_data;

  // Each word bit gathers field bit (b - off); out-of-word field bits simply never match.
  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic signed [31:0] w_rel;
    assign w_rel     = b - int'(w_off);
    assign w_mask[b] = (w_rel >= 0) && (w_rel < FIELD);
    assign w_val[b]  = w_data[w_rel[C_FW-1:0]];
  end

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    assign w_wsel[w] = (w_word == IDXW'(w));
    assign w_csel[w] = (r_clr_word == IDXW'(w));
    assign w_cin[w]  = (clr_word == IDXW'(w));
  end

  assign w_clr_mask = WIDTH'({FIELD{1'b1}}) << (FIELD * r_k);

  always_comb begin
    w_rd = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (rd_word == IDXW'(w)) w_rd = r_data[w];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int w = 0; w < WORDS; w++) r_data[w] <= '0;
    end else begin
      for (int w = 0; w < WORDS; w++) begin
        if (r_state == S_CLEAR && w_csel[w])
          r_data[w] <= r_data[w] & ~w_clr_mask;
        else if (w_wr && w_wsel[w])
          r_data[w] <= (r_data[w] & ~w_mask) | (w_val & w_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= '0;
      r_last_grant <= 1'b1;
      r_clr_word   <= '0;
      r_err        <= 1'b0;
      r_rd_data    <= '0;
    end else begin
      r_rd_data <= w_rd;
      r_err     <= (w_wr && !(|w_wsel)) || (clr_ready && !(|w_cin));
      if (clr_ready) begin
        r_clr_word <= clr_word;
        r_k        <= '0;
      end else if (r_state == S_CLEAR) begin
        r_k <= (r_k == C_KW'(C_SLICES - 1)) ? '0 : r_k + 1'b1;
      end
      if (req0_ready)      r_last_grant <= 1'b0;
      else if (req1_ready) r_last_grant <= 1'b1;
    end
  end

  assign rd_data = r_rd_data;
  assign busy    = (r_state == S_CLEAR);
  assign err     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_field_write_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_field_write_sched
// Purpose : Directed vector table plus hand sequences for field_write_sched.
// Revision: 1.0 - initial release
// ============================================================================
module tb_field_write_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_word, req1_word, clr_word, rd_word;
  logic [7:0]  req0_off, req1_off, req0_data, req1_data;
  logic        clr_valid, clr_ready, busy, err;
  logic [31:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  field_write_sched dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_word(req0_word),
    .req0_off(req0_off), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_word(req1_word),
    .req1_off(req1_off), .req1_data(req1_data),
    .clr_valid(clr_valid), .clr_ready(clr_ready), .clr_word(clr_word),
    .rd_word(rd_word), .rd_data(rd_data), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rq;
    logic [1:0]  word;
    logic [7:0]  off;
    logic [7:0]  data;
    logic [1:0]  rdw;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl[12];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs;
    req0_valid = 0; req1_valid = 0; clr_valid = 0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic wr0(input logic [1:0] w, input logic [7:0] o, input logic [7:0] d);
    req0_word = w; req0_off = o; req0_data = d; req0_valid = 1;
    tick();
    req0_valid = 0;
  endtask

  initial begin
    //             rq word off    data   rdw exp_rd         err
    tbl[0]  = '{0, 2'd1, 8'h08, 8'hA5, 2'd1, 32'h0000A500, 0};
    tbl[1]  = '{0, 2'd0, 8'hFC, 8'hFF, 2'd0, 32'h0000000F, 0};
    tbl[2]  = '{1, 2'd0, 8'h1C, 8'hFF, 2'd0, 32'hF000000F, 0};
    tbl[3]  = '{0, 2'd0, 8'hF6, 8'hFF, 2'd0, 32'hF000000F, 0};
    tbl[4]  = '{1, 2'd0, 8'h28, 8'hFF, 2'd0, 32'hF000000F, 0};
    tbl[5]  = '{0, 2'd0, 8'hF8, 8'hFF, 2'd0, 32'hF000000F, 0};
    tbl[6]  = '{1, 2'd0, 8'h20, 8'h12, 2'd0, 32'hF000000F, 0};
    tbl[7]  = '{1, 2'd3, 8'h00, 8'hFF, 2'd0, 32'hF000000F, 1};
    tbl[8]  = '{0, 2'd0, 8'h04, 8'h5A, 2'd0, 32'hF00005AF, 0};
    tbl[9]  = '{1, 2'd1, 8'hFF, 8'h03, 2'd1, 32'h0000A501, 0};
    tbl[10] = '{0, 2'd1, 8'h1F, 8'h01, 2'd1, 32'h8000A501, 0};
    tbl[11] = '{0, 2'd2, 8'h00, 8'h55, 2'd1, 32'h8000A501, 1};

    req0_word = 0; req0_off = 0; req0_data = 0;
    req1_word = 0; req1_off = 0; req1_data = 0;
    clr_word = 0; rd_word = 0;
    #1;
    do_reset();
    tick();
    chk("reset_rd", rd_data, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_err", {31'b0, err}, 32'h0);
    chk("reset_rdy", {30'b0, req0_ready, req1_ready}, 32'h0);

    // Single-requester vectors
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rq == 0) begin
        req0_word = tbl[i].word; req0_off = tbl[i].off; req0_data = tbl[i].data; req0_valid = 1;
      end else begin
        req1_word = tbl[i].word; req1_off = tbl[i].off; req1_data = tbl[i].data; req1_valid = 1;
      end
      #1;
      chk($sformatf("v%0d_ready", i), {30'b0, req0_ready, req1_ready},
          tbl[i].rq ? 32'h1 : 32'h2);
      tick();
      idle_inputs();
      chk($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      rd_word = tbl[i].rdw;
      tick();
      chk($sformatf("v%0d_rd", i), rd_data, tbl[i].exp_rd);
      chk($sformatf("v%0d_errpulse", i), {31'b0, err}, 32'h0);
    end
    rd_word = 2;
    tick();
    chk("rd_oob", rd_data, 32'h0);

    // Round-robin ties from reset
    do_reset();
    req0_word = 0; req0_off = 8'h00; req0_data = 8'h11; req0_valid = 1;
    req1_word = 0; req1_off = 8'h18; req1_data = 8'h22; req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("tie%0d", i), {30'b0, req0_ready, req1_ready},
          (i % 2 == 0) ? 32'h2 : 32'h1);
      tick();
    end
    idle_inputs();
    rd_word = 0;
    tick();
    chk("tie_word0", rd_data, 32'h22000011);

    // Clear sweep with req0 waiting
    wr0(2'd1, 8'd0, 8'hFF);
    wr0(2'd1, 8'd8, 8'hFF);
    wr0(2'd1, 8'd16, 8'hFF);
    wr0(2'd1, 8'd24, 8'hFF);
    rd_word = 1;
    clr_word = 1; clr_valid = 1;
    req0_word = 0; req0_off = 8'h08; req0_data = 8'h77; req0_valid = 1;
    #1;
    chk("clr_accept", {30'b0, clr_ready, req0_ready}, 32'h2);
    tick();
    clr_valid = 0;
    begin
      logic [31:0] exp_sw [1:4];
      exp_sw[1] = 32'hFFFFFFFF; exp_sw[2] = 32'hFFFFFFFF;
      exp_sw[3] = 32'hFFFFFF00; exp_sw[4] = 32'hFFFF0000;
      for (int m = 1; m <= 4; m++) begin
        chk($sformatf("clr_busy%0d", m), {30'b0, busy, req0_ready}, 32'h2);
        chk($sformatf("clr_rd%0d", m), rd_data, exp_sw[m]);
        chk($sformatf("clr_err%0d", m), {31'b0, err}, 32'h0);
        tick();
      end
    end
    chk("clr_done", {30'b0, busy, req0_ready}, 32'h1);
    chk("clr_rd5", rd_data, 32'hFF000000);
    tick();
    req0_valid = 0;
    chk("clr_rd6", rd_data, 32'h0);
    rd_word = 0;
    tick();
    chk("post_clr_word0", rd_data, 32'h22007711);

    // Out-of-range clear
    clr_word = 3; clr_valid = 1;
    #1;
    chk("clr3_ready", {31'b0, clr_ready}, 32'h1);
    tick();
    clr_valid = 0;
    chk("clr3_err", {30'b0, err, busy}, 32'h3);
    tick();
    chk("clr3_errpulse", {31'b0, err}, 32'h0);
    tick(); tick(); tick();
    chk("clr3_idle", {31'b0, busy}, 32'h0);
    rd_word = 0;
    tick();
    chk("clr3_word0", rd_data, 32'h22007711);

    // Reset in the middle of a sweep
    req1_word = 1; req1_off = 8'h00; req1_data = 8'hAB; req1_valid = 1;
    tick();
    req1_valid = 0;
    clr_word = 0; clr_valid = 1;
    tick();
    clr_valid = 0;
    tick(); tick();
    rst = 1;
    req0_word = 0; req0_off = 8'h00; req0_data = 8'h11; req0_valid = 1;
    req1_word = 1; req1_off = 8'h00; req1_data = 8'h22; req1_valid = 1;
    tick();
    rst = 0;
    #1;
    chk("rstmid_state", {29'b0, busy, req0_ready, req1_ready}, 32'h2);
    idle_inputs();
    rd_word = 0;
    tick();
    chk("rstmid_w0", rd_data, 32'h0);
    rd_word = 1;
    tick();
    chk("rstmid_w1", rd_data, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
